// File: rtl/nios_pio_pkg.sv
// Shared constants for the nios_pio_in_edgecap input port: register word
// addresses, edge-type encodings and the startup counter width.
package nios_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int STARTUP_W = 3;

endpackage : nios_pio_pkg

// File: rtl/nios_pio_debounce.sv
// Single-bit debounce filter: the output follows the synchronised input only
// after it has differed from the output for DEBOUNCE_CYC consecutive cycles.
module nios_pio_debounce
#(
    parameter int DEBOUNCE_CYC = 16
)
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic sync_i,
    output logic filt_o
);
    import nios_pio_pkg::*;

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            filt_d = sync_i;
            cnt_d  = '0;
        end else if (sync_i == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = sync_i;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    // Bypass during startup so the edge detector's prev sees the loaded value in the same cycle.
    assign filt_o = load_i ? sync_i : filt_q;

endmodule : nios_pio_debounce

// File: rtl/nios_pio_in_edgecap.sv
// Avalon-MM input port with synchroniser, per-bit edge capture and masked level IRQ.
// Define NIOS_PIO_DEBOUNCE_EN to insert a per-bit debounce filter after the synchroniser.
module nios_pio_in_edgecap
#(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int EDGE_TYPE    = 2,
    parameter int DEBOUNCE_CYC = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    import nios_pio_pkg::*;

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY || DEBOUNCE_CYC < 1) begin : g_bad_cfg
        $error("nios_pio_in_edgecap: parameter out of range");
    end

    localparam logic [STARTUP_W-1:0] STARTUP_LAST = STARTUP_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  filt;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  rise, fall, edge_sel;
    logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
    logic [WIDTH-1:0]                  w1c;
    logic [STARTUP_W-1:0]              startup_q, startup_d;
    logic                              startup_done;
    logic                              irq_q, irq_d;
    logic [31:0]                       readdata_q, readdata_d;
    logic                              unused_inputs;

    // The read strobe is ignored and only the low WIDTH write bits are meaningful.
    assign unused_inputs = ^{read, writedata};

    // NOTE: every synchroniser flop is reset so startup suppression begins from a known all-zero history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync         = sync_q[SYNC_STAGES-1];
    assign startup_done = (startup_q == STARTUP_LAST);
    assign startup_d    = startup_done ? startup_q : startup_q + STARTUP_W'(1);

`ifdef NIOS_PIO_DEBOUNCE_EN
    for (genvar b = 0; b < WIDTH; b++) begin : g_debounce
        nios_pio_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .load_i (~startup_done),
            .sync_i (sync[b]),
            .filt_o (filt[b])
        );
    end
`else
    assign filt = sync;
`endif

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;

    // NOTE: each always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        edge_sel = rise | fall;
        case (EDGE_TYPE)
            EDGE_RISE: edge_sel = rise;
            EDGE_FALL: edge_sel = fall;
            default:   edge_sel = rise | fall;
        endcase
    end

    always_comb begin
        irqmask_d = irqmask_q;
        w1c       = '0;
        if (write && address == PIO_ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (write && address == PIO_ADDR_EDGECAP) begin
            w1c = writedata[WIDTH-1:0];
        end
        // A fresh edge is ORed in after the clear, so it wins over a same-cycle W1C.
        edgecap_d = (edgecap_q & ~w1c) | (startup_done ? edge_sel : '0);
        irq_d     = |(edgecap_d & irqmask_d);
    end

    always_comb begin
        readdata_d = 32'd0;
        case (address)
            PIO_ADDR_DATA:    readdata_d = 32'(filt);
            PIO_ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
            PIO_ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            default:          readdata_d = 32'd0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            startup_q  <= '0;
            irq_q      <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            prev_q     <= filt;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            startup_q  <= startup_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule : nios_pio_in_edgecap

// File: tb/tb_nios_pio_in_edgecap.sv
// Directed self-checking bench for nios_pio_in_edgecap (WIDTH=8, SYNC_STAGES=2, rising-edge capture).
module tb_nios_pio_in_edgecap;

    localparam int WIDTH        = 8;
    localparam int SYNC_STAGES  = 2;
    localparam int DEBOUNCE_CYC = 16;
`ifdef NIOS_PIO_DEBOUNCE_EN
    localparam int FILT_LAT = DEBOUNCE_CYC;
`else
    localparam int FILT_LAT = 0;
`endif
    // Edge at which a pin change sampled after edge 0 lands in EDGECAP.
    localparam int CAP_LAT = SYNC_STAGES + 1 + FILT_LAT;
    localparam int SETTLE  = CAP_LAT + 1;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_RSVD = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_CAP  = 2'd3;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             read;
    logic             write;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  in_val;
        logic [31:0] exp_data;
        logic [31:0] exp_cap;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [6];

    nios_pio_in_edgecap #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .EDGE_TYPE    (0),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = 32'd0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        d       = readdata;
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0] = '{8'h5A, 32'h0000_005A, 32'h0000_005A, 1'b1};
        vecs[1] = '{8'hFF, 32'h0000_00FF, 32'h0000_00A5, 1'b1};
        vecs[2] = '{8'h00, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{8'h81, 32'h0000_0081, 32'h0000_0081, 1'b1};
        vecs[4] = '{8'h3C, 32'h0000_003C, 32'h0000_003C, 1'b1};
        vecs[5] = '{8'hA5, 32'h0000_00A5, 32'h0000_0081, 1'b1};

        // Inputs held high through reset must not produce captures.
        reset     = 1'b1;
        address   = A_DATA;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'd0;
        in_port   = 8'hA5;
        wait_cycles(3);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(5 + FILT_LAT);
        do_read(A_DATA, rd);
        check("startup_data", rd, 32'h0000_00A5);
        do_read(A_CAP, rd);
        check("startup_edgecap", rd, 32'd0);
        check("startup_irq", {31'd0, irq}, 32'd0);

        // Table: rising edges relative to the previous pattern, all bits unmasked.
        do_write(A_MASK, 32'h0000_00FF);
        for (int v = 0; v < 6; v++) begin
            do_write(A_CAP, 32'h0000_00FF);
            in_port = vecs[v].in_val;
            wait_cycles(SETTLE);
            do_read(A_DATA, rd);
            check($sformatf("vec%0d_data", v), rd, vecs[v].exp_data);
            do_read(A_CAP, rd);
            check($sformatf("vec%0d_edgecap", v), rd, vecs[v].exp_cap);
            check($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
        end

        // Bit0 rising edge: exact capture latency, IRQ, then W1C.
        do_write(A_MASK, 32'h0000_0001);
        do_write(A_CAP, 32'h0000_00FF);
        check("t2_cleared_irq", {31'd0, irq}, 32'd0);
        in_port = 8'hA4;
        wait_cycles(SETTLE);
        do_read(A_CAP, rd);
        check("t2_fall_ignored", rd, 32'd0);
        in_port = 8'hA5;
        address = A_CAP;
        wait_cycles(CAP_LAT - 1);
        check("t2_irq_before_capture", {31'd0, irq}, 32'd0);
        tick();
        check("t2_irq_at_capture", {31'd0, irq}, 32'd1);
        tick();
        check("t2_edgecap_read", readdata, 32'h0000_0001);
        do_write(A_CAP, 32'h0000_0001);
        check("t2_irq_after_w1c", {31'd0, irq}, 32'd0);
        do_read(A_CAP, rd);
        check("t2_edgecap_after_w1c", rd, 32'd0);

        // W1C landing on the same edge as a new capture: the capture wins.
        in_port = 8'hA4;
        wait_cycles(SETTLE);
        in_port = 8'hA5;
        wait_cycles(SETTLE);
        check("t3_pending_irq", {31'd0, irq}, 32'd1);
        in_port = 8'hA4;
        wait_cycles(SETTLE);
        in_port = 8'hA5;
        wait_cycles(CAP_LAT - 1);
        do_write(A_CAP, 32'h0000_0001);
        check("t3_irq_stays", {31'd0, irq}, 32'd1);
        do_read(A_CAP, rd);
        check("t3_edgecap_stays", rd, 32'h0000_0001);
        do_write(A_CAP, 32'h0000_0001);
        do_read(A_CAP, rd);
        check("t3_plain_w1c", rd, 32'd0);

        // Masked pending capture, zero-writes, reserved address, unmask/mask.
        do_write(A_MASK, 32'd0);
        do_write(A_CAP, 32'h0000_00FF);
        in_port = 8'hA1;
        wait_cycles(SETTLE);
        in_port = 8'hA5;
        wait_cycles(SETTLE);
        do_read(A_CAP, rd);
        check("t4_edgecap_pending", rd, 32'h0000_0004);
        check("t4_irq_masked", {31'd0, irq}, 32'd0);
        do_write(A_CAP, 32'd0);
        do_read(A_CAP, rd);
        check("t4_zero_write_no_effect", rd, 32'h0000_0004);
        do_write(A_RSVD, 32'hFFFF_FFFF);
        do_read(A_RSVD, rd);
        check("t4_addr1_reads_zero", rd, 32'd0);
        do_read(A_MASK, rd);
        check("t4_mask_untouched", rd, 32'd0);
        do_write(A_MASK, 32'h0000_0004);
        check("t4_irq_on_unmask", {31'd0, irq}, 32'd1);
        do_read(A_MASK, rd);
        check("t4_mask_readback", rd, 32'h0000_0004);
        do_write(A_MASK, 32'd0);
        check("t4_irq_on_mask", {31'd0, irq}, 32'd0);

`ifdef NIOS_PIO_DEBOUNCE_EN
        // Short glitch rejected; long pulse accepted exactly DEBOUNCE_CYC cycles after sync.
        do_write(A_CAP, 32'h0000_00FF);
        in_port = 8'hAD;
        wait_cycles(10);
        in_port = 8'hA5;
        wait_cycles(SETTLE);
        do_read(A_DATA, rd);
        check("t5_glitch_data", rd, 32'h0000_00A5);
        do_read(A_CAP, rd);
        check("t5_glitch_edgecap", rd, 32'd0);
        in_port = 8'hAD;
        address = A_DATA;
        wait_cycles(SYNC_STAGES + DEBOUNCE_CYC);
        check("t5_data_before_accept", readdata, 32'h0000_00A5);
        tick();
        check("t5_data_at_accept", readdata, 32'h0000_00AD);
        wait_cycles(20 - (SYNC_STAGES + DEBOUNCE_CYC + 1));
        in_port = 8'hA5;
        wait_cycles(SETTLE);
        do_read(A_CAP, rd);
        check("t5_long_pulse_edgecap", rd, 32'h0000_0008);
`endif

        // Reset while a capture is pending and an input change is in flight.
        do_write(A_MASK, 32'h0000_00FF);
        do_write(A_CAP, 32'h0000_00FF);
        in_port = 8'h00;
        wait_cycles(SETTLE);
        in_port = 8'hFF;
        wait_cycles(SETTLE);
        do_read(A_CAP, rd);
        check("t6_edgecap_full", rd, 32'h0000_00FF);
        check("t6_irq_before_reset", {31'd0, irq}, 32'd1);
        in_port = 8'h00;
        wait_cycles(3);
        address = A_CAP;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_readdata", readdata, 32'd0);
        check("t6_async_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        in_port = 8'hFF;
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(CAP_LAT + 3);
        do_read(A_CAP, rd);
        check("t6_no_startup_capture", rd, 32'd0);
        do_read(A_MASK, rd);
        check("t6_mask_cleared", rd, 32'd0);
        do_read(A_DATA, rd);
        check("t6_data_after_reset", rd, 32'h0000_00FF);
        check("t6_irq_after_reset", {31'd0, irq}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_nios_pio_in_edgecap
